// File: rtl/regfile_pkg.sv
// Shared sizing constants for the register file and its sub-blocks.
// Latency: none, constants only.
// Backpressure: none, constants only.
package regfile_pkg;
    localparam int REG_COUNT      = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int DATA_W_DEFAULT = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;
endpackage : regfile_pkg

// File: rtl/regfile_mux32.sv
// 32:1 read multiplexer selecting one WIDTH-bit word by a 5-bit index.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module regfile_mux32
    import regfile_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEFAULT
) (
    input  logic [REG_COUNT-1:0][WIDTH-1:0] d_i,
    input  logic [REG_ADDR_W-1:0]           sel_i,
    output logic [WIDTH-1:0]                y_o
);
    // Plain indexed select over the 32 inputs.
    always_comb begin
        y_o = d_i[sel_i];
    end
endmodule : regfile_mux32

// File: rtl/register32.sv
// Single WIDTH-bit storage register with load enable and synchronous reset.
// Latency: loaded value appears on q_o one cycle after the enabling edge.
// Backpressure: none; a load is always accepted, reset overrides the load.
module register32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next state: hold unless enabled; reset is applied in the flop block so it wins.
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    // State register with synchronous active-high clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;
endmodule : register32

// File: rtl/regfile.sv
// 32 x WIDTH register file: one synchronous write port, two async read ports, r0 fixed at zero.
// Latency: write visible on reads right after its edge; reads zero-cycle (or same-cycle with WRITE_THROUGH).
// Backpressure: none; every write is accepted unless reset is high on the same edge.
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH         = DATA_W_DEFAULT,
    parameter bit WRITE_THROUGH = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regwrite,
    input  logic [REG_ADDR_W-1:0] writeregister,
    input  logic [WIDTH-1:0]      writedata,
    input  logic [REG_ADDR_W-1:0] readregister1,
    input  logic [REG_ADDR_W-1:0] readregister2,
    output logic [WIDTH-1:0]      readdata1,
    output logic [WIDTH-1:0]      readdata2
);
    logic [REG_COUNT-1:0]            we_d;
    logic [REG_COUNT-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]                mux1_dat;
    logic [WIDTH-1:0]                mux2_dat;

    // One-hot write-enable decode; bit 0 is forced low so r0 can never be loaded.
    always_comb begin
        we_d = '0;
        if (regwrite) begin
            we_d[writeregister] = 1'b1;
        end
        we_d[ZERO_REG] = 1'b0;
    end

    // r0 is a constant, not storage.
    assign regs[0] = '0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        register32 #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en_i  (we_d[i]),
            .d_i   (writedata),
            .q_o   (regs[i])
        );
    end

    regfile_mux32 #(.WIDTH(WIDTH)) u_mux1 (
        .d_i   (regs),
        .sel_i (readregister1),
        .y_o   (mux1_dat)
    );

    regfile_mux32 #(.WIDTH(WIDTH)) u_mux2 (
        .d_i   (regs),
        .sel_i (readregister2),
        .y_o   (mux2_dat)
    );

    if (WRITE_THROUGH) begin : g_bypass
        logic byp1;
        logic byp2;

        // Forward in-flight write data only when that write will actually land on this edge.
        always_comb begin
            byp1 = regwrite && !reset && (writeregister == readregister1)
                   && (readregister1 != ZERO_REG);
            byp2 = regwrite && !reset && (writeregister == readregister2)
                   && (readregister2 != ZERO_REG);
            readdata1 = byp1 ? writedata : mux1_dat;
            readdata2 = byp2 ? writedata : mux2_dat;
        end
    end else begin : g_no_bypass
        assign readdata1 = mux1_dat;
        assign readdata2 = mux2_dat;
    end
endmodule : regfile

// File: tb/tb_regfile.sv
// Directed self-checking bench: one instance without and one with write-through, shared stimulus.
// Latency: checks are taken 3 time units after each rising edge, well before the next.
// Backpressure: not applicable.
module tb_regfile;
    logic        clk;
    logic        reset;
    logic        regwrite;
    logic [4:0]  writeregister;
    logic [31:0] writedata;
    logic [4:0]  readregister1;
    logic [4:0]  readregister2;
    logic [31:0] rd1_a, rd2_a;   // WRITE_THROUGH = 0
    logic [31:0] rd1_b, rd2_b;   // WRITE_THROUGH = 1

    int compared   = 0;
    int mismatched = 0;

    regfile #(.WIDTH(32), .WRITE_THROUGH(1'b0)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .regwrite      (regwrite),
        .writeregister (writeregister),
        .writedata     (writedata),
        .readregister1 (readregister1),
        .readregister2 (readregister2),
        .readdata1     (rd1_a),
        .readdata2     (rd2_a)
    );

    regfile #(.WIDTH(32), .WRITE_THROUGH(1'b1)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .regwrite      (regwrite),
        .writeregister (writeregister),
        .writedata     (writedata),
        .readregister1 (readregister1),
        .readregister2 (readregister2),
        .readdata1     (rd1_b),
        .readdata2     (rd2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven after this point.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; regwrite = 1'b0; writeregister = 5'd0; writedata = '0;
        readregister1 = 5'd0; readregister2 = 5'd0;

        // r0 reads zero even before any reset edge
        settle();
        chk("pre_reset_r0_a", rd1_a, 32'h0);
        chk("pre_reset_r0_b", rd1_b, 32'h0);

        tick();
        reset = 1'b0; readregister1 = 5'd1; readregister2 = 5'd17;
        settle();
        chk("reset_r1", rd1_a, 32'h0);
        chk("reset_r17", rd2_a, 32'h0);

        // Test 1: load r5 then reset clears it
        regwrite = 1'b1; writeregister = 5'd5; writedata = 32'hDEADBEEF;
        tick();
        regwrite = 1'b0; readregister1 = 5'd5; readregister2 = 5'd31;
        settle();
        chk("r5_loaded", rd1_a, 32'hDEADBEEF);
        reset = 1'b1;
        settle();
        chk("r5_held_reset_pending", rd1_a, 32'hDEADBEEF);
        tick();
        reset = 1'b0;
        settle();
        chk("r5_after_reset", rd1_a, 32'h0);
        chk("r31_after_reset", rd2_a, 32'h0);

        // Test 2: write/read on two ports
        regwrite = 1'b1; writeregister = 5'd7; writedata = 32'h12345678;
        tick();
        writeregister = 5'd12; writedata = 32'hCAFEF00D;
        tick();
        regwrite = 1'b0; readregister1 = 5'd7; readregister2 = 5'd12;
        settle();
        chk("r7_port1", rd1_a, 32'h12345678);
        chk("r12_port2", rd2_a, 32'hCAFEF00D);
        readregister1 = 5'd12;
        settle();
        chk("r12_both_p1", rd1_a, 32'hCAFEF00D);
        chk("r12_both_p2", rd2_a, 32'hCAFEF00D);

        // Test 3: writes to r0 are ignored, no bypass on r0
        regwrite = 1'b1; writeregister = 5'd0; writedata = 32'hFFFFFFFF; readregister1 = 5'd0;
        settle();
        chk("r0_before_edge_a", rd1_a, 32'h0);
        chk("r0_before_edge_b", rd1_b, 32'h0);
        tick();
        settle();
        chk("r0_after_edge_a", rd1_a, 32'h0);
        chk("r0_after_edge_b", rd1_b, 32'h0);

        // Test 4: regwrite=0 gates writes
        writeregister = 5'd3; writedata = 32'hAAAA5555;
        tick();
        regwrite = 1'b0; writedata = 32'h11111111; readregister1 = 5'd3;
        tick(); tick(); tick();
        settle();
        chk("r3_gated_a", rd1_a, 32'hAAAA5555);
        chk("r3_gated_b", rd1_b, 32'hAAAA5555);

        // Test 5: reset beats a simultaneous write; reset also suppresses bypass
        reset = 1'b1; regwrite = 1'b1; writeregister = 5'd9; writedata = 32'h0BADF00D;
        readregister1 = 5'd9; readregister2 = 5'd3;
        settle();
        chk("no_bypass_under_reset", rd1_b, 32'h0);
        chk("r3_before_reset_edge", rd2_a, 32'hAAAA5555);
        tick();
        reset = 1'b0; regwrite = 1'b0;
        settle();
        chk("r9_write_dropped", rd1_a, 32'h0);
        chk("r3_cleared", rd2_a, 32'h0);
        regwrite = 1'b1;
        tick();
        regwrite = 1'b0;
        settle();
        chk("r9_written", rd1_a, 32'h0BADF00D);

        // Test 6: read-during-write on r4
        regwrite = 1'b1; writeregister = 5'd4; writedata = 32'h1;
        tick();
        writedata = 32'h2; readregister1 = 5'd4; readregister2 = 5'd9;
        settle();
        chk("rdw_old_wt0", rd1_a, 32'h1);
        chk("rdw_new_wt1", rd1_b, 32'h2);
        chk("rdw_other_port_wt1", rd2_b, 32'h0BADF00D);
        tick();
        regwrite = 1'b0;
        settle();
        chk("rdw_after_edge_wt0", rd1_a, 32'h2);

        // Back-to-back writes to one register: each visible for one cycle
        regwrite = 1'b1; writeregister = 5'd20; writedata = 32'h00000A0A; readregister1 = 5'd20;
        tick();
        writedata = 32'h0000B0B0;
        settle();
        chk("b2b_first", rd1_a, 32'h00000A0A);
        tick();
        regwrite = 1'b0;
        settle();
        chk("b2b_second", rd1_a, 32'h0000B0B0);
        chk("b2b_second_wt1", rd1_b, 32'h0000B0B0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule : tb_regfile
